// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and buffers
// redirects that arrive while stalled. Optional fetch address-error check: PC_FETCH_ADEL_EN.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter logic [31:0] EXC_VEC  = 32'hBFC0_0380
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic [32:0] br_bus,
   output logic [32:0] if_to_id_bus,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_wen,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   output logic        fetch_adel,
   output logic [31:0] fetch_badvaddr
);

   localparam logic STOP = 1'b1;

   logic [31:0] pc_reg;
   logic        ce_reg;
   logic        pend_v;
   logic [31:0] pend_addr;
   logic        adel_reg;
   logic [31:0] bad_reg;

   logic        br_e;
   logic [31:0] br_addr;
   logic [31:0] next_pc;

   assign br_e    = br_bus[32];
   assign br_addr = br_bus[31:0];

   // A live redirect beats a buffered one; the buffered one beats sequential fetch.
   always_comb begin
      next_pc = pc_reg + 32'd4;
      if (br_e)
         next_pc = br_addr;
      else if (pend_v)
         next_pc = pend_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg    <= RESET_PC - 32'd4;
         ce_reg    <= 1'b0;
         pend_v    <= 1'b0;
         pend_addr <= 32'd0;
         adel_reg  <= 1'b0;
         bad_reg   <= 32'd0;
      end else begin
         adel_reg <= 1'b0;
         if (stall[0] != STOP) begin
            ce_reg <= 1'b1;
            pend_v <= 1'b0;
`ifdef PC_FETCH_ADEL_EN
            if (next_pc[1:0] != 2'b00) begin
               pc_reg   <= EXC_VEC;
               bad_reg  <= next_pc;
               adel_reg <= 1'b1;
            end else begin
               pc_reg <= next_pc;
            end
`else
            pc_reg <= next_pc;
`endif
         end else if (br_e) begin
            // The newest target resolved during a stall is the one that survives.
            pend_v    <= 1'b1;
            pend_addr <= br_addr;
         end
      end
   end

   assign if_to_id_bus    = {ce_reg, pc_reg};
   assign inst_sram_addr  = pc_reg;
   assign inst_sram_wen   = 4'b0000;
   assign inst_sram_wdata = 32'd0;

`ifdef PC_FETCH_ADEL_EN
   assign inst_sram_en   = ce_reg & ~adel_reg;
   assign fetch_adel     = adel_reg;
   assign fetch_badvaddr = bad_reg;
`else
   assign inst_sram_en   = ce_reg;
   assign fetch_adel     = 1'b0;
   assign fetch_badvaddr = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch: boot, branches, buffered redirects, reset
// during a stall, PC wrap and the fetch address-error path.
module tb_pc_fetch;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic [32:0] br_bus;
   logic [32:0] if_to_id_bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        fetch_adel;
   logic [31:0] fetch_badvaddr;

   int testCount = 0;
   int failCount = 0;

   pc_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .br_bus          (br_bus),
      .if_to_id_bus    (if_to_id_bus),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_wen   (inst_sram_wen),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .fetch_adel      (fetch_adel),
      .fetch_badvaddr  (fetch_badvaddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the clock edge.
   task automatic applyStimulus(input logic r, input logic [5:0] s, input logic be, input logic [31:0] ba);
      rst    = r;
      stall  = s;
      br_bus = {be, ba};
      @(posedge clk);
      #1;
   endtask

   task automatic checkPc(input string tag, input logic ce, input logic [31:0] pc);
      checkOutput({tag, "_bus"}, 64'(if_to_id_bus), 64'({ce, pc}));
      checkOutput({tag, "_addr"}, 64'(inst_sram_addr), 64'(pc));
   endtask

   initial begin
      rst = 1'b1; stall = 6'd0; br_bus = 33'd0;

      applyStimulus(1'b1, 6'd0, 1'b0, 32'd0);
      applyStimulus(1'b1, 6'd0, 1'b1, 32'h1234_5678);
      checkPc("reset", 1'b0, 32'hBFBF_FFFC);
      checkOutput("reset_en", 64'(inst_sram_en), 64'd0);
      checkOutput("reset_adel", 64'(fetch_adel), 64'd0);
      checkOutput("reset_bad", 64'(fetch_badvaddr), 64'd0);
      checkOutput("reset_pend", 64'(dut.pend_v), 64'd0);
      checkOutput("reset_pend_addr", 64'(dut.pend_addr), 64'd0);
      checkOutput("wen", 64'(inst_sram_wen), 64'd0);
      checkOutput("wdata", 64'(inst_sram_wdata), 64'd0);

      // Boot sequence
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("boot0", 1'b1, 32'hBFC0_0000);
      checkOutput("boot0_en", 64'(inst_sram_en), 64'd1);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("boot1", 1'b1, 32'hBFC0_0004);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("boot2", 1'b1, 32'hBFC0_0008);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("seq", 1'b1, 32'hBFC0_0010);

      // Branch
      applyStimulus(1'b0, 6'd0, 1'b1, 32'hBFC0_0040);
      checkPc("br", 1'b1, 32'hBFC0_0040);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("br_next", 1'b1, 32'hBFC0_0044);

      // Pending redirect across a 3-cycle stall
      applyStimulus(1'b0, 6'b000001, 1'b1, 32'hBFC0_0100);
      checkPc("stall0", 1'b1, 32'hBFC0_0044);
      checkOutput("stall0_pend", 64'(dut.pend_v), 64'd1);
      applyStimulus(1'b0, 6'b000001, 1'b0, 32'd0);
      checkPc("stall1", 1'b1, 32'hBFC0_0044);
      applyStimulus(1'b0, 6'b000001, 1'b0, 32'd0);
      checkPc("stall2", 1'b1, 32'hBFC0_0044);
      checkOutput("stall2_en", 64'(inst_sram_en), 64'd1);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("pend_taken", 1'b1, 32'hBFC0_0100);
      checkOutput("pend_clr", 64'(dut.pend_v), 64'd0);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("pend_next", 1'b1, 32'hBFC0_0104);

      // Live redirect beats pending on release
      applyStimulus(1'b0, 6'b000011, 1'b1, 32'hBFC0_0100);
      checkPc("sim_stall", 1'b1, 32'hBFC0_0104);
      applyStimulus(1'b0, 6'd0, 1'b1, 32'hBFC0_0200);
      checkPc("sim_live", 1'b1, 32'hBFC0_0200);
      checkOutput("sim_pend_clr", 64'(dut.pend_v), 64'd0);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("sim_next", 1'b1, 32'hBFC0_0204);

      // Newer stalled redirect overwrites older one
      applyStimulus(1'b0, 6'b000001, 1'b1, 32'hBFC0_0500);
      applyStimulus(1'b0, 6'b000001, 1'b1, 32'hBFC0_0600);
      checkOutput("ovr_pend_addr", 64'(dut.pend_addr), 64'h0000_0000_BFC0_0600);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("ovr", 1'b1, 32'hBFC0_0600);

      // Reset while a redirect is pending
      applyStimulus(1'b0, 6'b000001, 1'b1, 32'hBFC0_0700);
      checkOutput("rst_pre_pend", 64'(dut.pend_v), 64'd1);
      applyStimulus(1'b1, 6'b000001, 1'b1, 32'hBFC0_0800);
      checkPc("rst_mid", 1'b0, 32'hBFBF_FFFC);
      checkOutput("rst_mid_pend", 64'(dut.pend_v), 64'd0);
      checkOutput("rst_mid_en", 64'(inst_sram_en), 64'd0);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("reboot0", 1'b1, 32'hBFC0_0000);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("reboot1", 1'b1, 32'hBFC0_0004);

      // 32-bit wrap
      applyStimulus(1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC);
      checkPc("wrap_pre", 1'b1, 32'hFFFF_FFFC);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("wrap", 1'b1, 32'h0000_0000);

      // Misaligned redirect
      applyStimulus(1'b0, 6'd0, 1'b1, 32'hBFC0_0042);
`ifdef PC_FETCH_ADEL_EN
      checkPc("adel", 1'b1, 32'hBFC0_0380);
      checkOutput("adel_pulse", 64'(fetch_adel), 64'd1);
      checkOutput("adel_bad", 64'(fetch_badvaddr), 64'h0000_0000_BFC0_0042);
      checkOutput("adel_en", 64'(inst_sram_en), 64'd0);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("adel_next", 1'b1, 32'hBFC0_0384);
      checkOutput("adel_end", 64'(fetch_adel), 64'd0);
      checkOutput("adel_bad_hold", 64'(fetch_badvaddr), 64'h0000_0000_BFC0_0042);
      checkOutput("adel_en_back", 64'(inst_sram_en), 64'd1);
`else
      checkPc("misal", 1'b1, 32'hBFC0_0042);
      checkOutput("misal_adel", 64'(fetch_adel), 64'd0);
      checkOutput("misal_bad", 64'(fetch_badvaddr), 64'd0);
      checkOutput("misal_en", 64'(inst_sram_en), 64'd1);
      applyStimulus(1'b0, 6'd0, 1'b0, 32'd0);
      checkPc("misal_next", 1'b1, 32'hBFC0_0046);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch (IF) stage of the five-stage MIPS pipeline. It owns the program counter, drives the synchronous instruction SRAM, and produces `if_to_id_bus` for the decode stage. It consumes the decode stage's branch/jump redirect (`br_bus`) and the pipeline stall vector. A redirect that arrives while IF is stalled is held in a one-entry buffer, so no resolved branch target is lost.

## Interface
- `RESET_PC`, default `32'hBFC0_0000`: first fetched address after reset.
- `EXC_VEC`, default `32'hBFC0_0380`: fetch address-error vector. Used only when the `PC_FETCH_ADEL_EN` feature is compiled in.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `stall` input `StallBus` (6): `stall[0]==Stop` freezes the PC.
- `br_bus` input `BR_WD` (33): `{br_e, br_addr[31:0]}` from decode.
- `if_to_id_bus` output `IF_TO_ID_WD` (33): `{ce, pc[31:0]}`.
- `inst_sram_en` output 1: read enable.
- `inst_sram_wen` output 4: always `4'b0000`.
- `inst_sram_addr` output 32: fetch address.
- `inst_sram_wdata` output 32: always `32'b0`.
- `fetch_adel` output 1: address-error pulse.
- `fetch_badvaddr` output 32: offending address.

## Operation
- **Registers:**
  - `pc_reg` (32), `ce_reg` (1).
  - `pend_v` (1), `pend_addr` (32): held redirect.
  - `adel_reg` (1), `bad_reg` (32).
- **Boot sequence:**
  - Reset loads `pc_reg = RESET_PC - 4` (`32'hBFBF_FFFC`) and `ce_reg = 0`.
  - The first non-stalled cycle after reset loads `pc_reg = RESET_PC` and `ce_reg = 1`.
- **next_pc priority (highest first):**
  1. Live `br_e` gives `br_addr`.
  2. `pend_v` gives `pend_addr`.
  3. Otherwise `pc_reg + 32'd4`, with 32-bit wrap: `32'hFFFF_FFFC + 4 = 0`.
- **Delay slot:**
  - When the branch is resolved in ID, IF has already fetched `branch_pc + 4`. That delay-slot instruction is never squashed.
  - The redirect replaces only the following fetch.
- **Update rules:**
  - `stall[0]==NoStop`: `pc_reg <= next_pc`, `ce_reg <= 1`, `pend_v <= 0`.
  - `stall[0]==Stop` with `br_e=1`: `pc_reg` holds; `pend_v <= 1`, `pend_addr <= br_addr`. A newer `br_e` overwrites an older pending target.
  - `stall[0]==Stop` with `br_e=0`: all state holds.
- **SRAM interface:**
  - `inst_sram_addr = pc_reg`.
  - `inst_sram_en = ce_reg`. Forced to 0 on an address error when the feature is enabled.
  - Writes are never issued.
- **Bus packing:** `if_to_id_bus = {ce_reg, pc_reg}`.

## Timing
- **Reset values:**
  - `if_to_id_bus = {1'b0, 32'hBFBF_FFFC}`, `inst_sram_en = 0`.
  - `fetch_adel = 0`, `fetch_badvaddr = 0`.
  - `pend_v = 0`, `pend_addr = 0`.
- **SRAM read latency:** 1 cycle. The address presented in cycle N returns data in cycle N+1, aligned with decode's registered copy of `if_to_id_bus`.
- **Redirect latency:**
  - `br_e` in cycle N with no stall: `pc_reg = br_addr` from cycle N+1.
  - Stalled cycles N..M, stall released in M+1: `pc_reg = pend_addr` in M+2.
- **Simultaneous events:**
  - Stall release with live `br_e` and `pend_v`: the live target wins and pending is cleared.
  - `rst` with any other input: reset wins, and a pending redirect is discarded.
- **Stall hold:** during a stall, `pc_reg` and `ce_reg` are stable, and the SRAM re-reads the same address.
- **Shared-slot stall:** `stall[0]==Stop` with `stall[1]==NoStop` is handled entirely by decode. Here the PC simply holds.

## Configuration
- **`PC_FETCH_ADEL_EN` defined:**
  - If a selected next_pc has `[1:0]!=0`, then `pc_reg <= EXC_VEC`, `bad_reg <= next_pc`, and `adel_reg` pulses for exactly 1 cycle.
  - In that cycle `inst_sram_en = 0`.
  - `fetch_badvaddr` holds its value until the next error.
- **`PC_FETCH_ADEL_EN` undefined:**
  - `fetch_adel` and `fetch_badvaddr` are tied 0.
  - Misaligned addresses are fetched unchanged; the SRAM ignores `[1:0]`.

## Test plan
- **Boot:** release `rst`, no stall. Required: `pc` sequence `BFBF_FFFC` (ce=0), then `BFC0_0000`, then `BFC0_0004`, then `BFC0_0008`, with ce=1 from the second cycle.
- **Branch:** at `pc=BFC0_0010`, drive `br_e=1`, `br_addr=BFC0_0040` for one cycle. Required: next pc is `BFC0_0040`, then `BFC0_0044`.
- **Pending redirect:** `stall[0]=1` for 3 cycles, `br_e=1`, `br_addr=BFC0_0100` in the first stalled cycle only. Required: pc constant during the stall, `BFC0_0100` one cycle after release, `pend_v` back to 0.
- **Simultaneous redirects:** pending `BFC0_0100`, release the stall with live `br_e=1`, `br_addr=BFC0_0200`. Required: pc becomes `BFC0_0200`.
- **Reset mid-stall:** `pend_v=1`, assert `rst`. Required: pc `BFBF_FFFC`, ce=0, `pend_v=0`, then normal boot.
- **Address error:** with `PC_FETCH_ADEL_EN`, drive `br_addr=BFC0_0042`. Required: pc becomes `BFC0_0380`, `fetch_adel=1` for exactly 1 cycle, `fetch_badvaddr=BFC0_0042`, `inst_sram_en=0` in that cycle. Without the macro: pc becomes `BFC0_0042`, `fetch_adel=0`.
